// File: rtl/lvds_tx_pkg.sv
// Shared definitions for the LVDS I/Q transmit path (also used by the receiver).
// Optional build macro used by this block: LVDS_TX_SYNC_FORCE_EN.
package lvds_pkg;

  localparam logic [1:0] LVDS_I_SYNC = 2'b10;
  localparam logic [1:0] LVDS_Q_SYNC = 2'b01;
  localparam int         LVDS_WORD_W = 32;
  localparam int         LVDS_PAIRS  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_TX   = 2'b11
  } lvds_state_e;

endpackage

// File: rtl/lvds_tx_if.sv
// TX FIFO read port as seen by the serializer.
// Handshake: the serializer raises fifo_pull for one cycle only while
// fifo_empty is low; the FIFO pops on that edge and the popped word is valid
// on fifo_data throughout the following cycle. There is no back-pressure.
interface lvds_tx_if;
  import lvds_pkg::*;

  logic                   fifo_empty;
  logic                   fifo_pull;
  logic [LVDS_WORD_W-1:0] fifo_data;

  modport master (output fifo_pull, input fifo_empty, input fifo_data);
  modport slave  (input fifo_pull, output fifo_empty, output fifo_data);
endinterface

// File: rtl/lvds_tx_shifter.sv
// 32-bit load/shift register plus 4-bit pair counter for the LVDS serializer.
// Pairs leave from the top two bits; the register refills with the idle pair
// so the output settles to the idle pattern once a word has drained.
// With LVDS_TX_SYNC_FORCE_EN defined, the sync fields are overwritten on load.
module lvds_tx_shifter
  import lvds_pkg::*;
#(
  parameter logic [1:0] IDLE_PATTERN = 2'b00
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic                   shift_i,
  input  logic [LVDS_WORD_W-1:0] data_in_i,
  output logic [1:0]             pair_out_o,
  output logic                   last_o,
  output logic                   prefetch_o
);

  logic [LVDS_WORD_W-1:0] shreg_q, shreg_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [LVDS_WORD_W-1:0] load_word;

`ifdef LVDS_TX_SYNC_FORCE_EN
  // Guarantee the modem always sees valid sync fields, whatever the FIFO holds.
  assign load_word = {LVDS_I_SYNC, data_in_i[29:16], LVDS_Q_SYNC, data_in_i[13:0]};
`else
  // FIFO content is trusted and sent verbatim.
  assign load_word = data_in_i;
`endif

  // Next-state: a load restarts the word, otherwise shift one pair out.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = load_word;
      cnt_d   = 4'd0;
    end else if (shift_i) begin
      shreg_d = {shreg_q[LVDS_WORD_W-3:0], IDLE_PATTERN};
      cnt_d   = cnt_q + 4'd1;
    end
  end

  // State registers; the output pair comes straight from these flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= {LVDS_PAIRS{IDLE_PATTERN}};
      cnt_q   <= 4'd0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pair_out_o = shreg_q[LVDS_WORD_W-1 -: 2];
  assign last_o     = (cnt_q == 4'd15);
  assign prefetch_o = (cnt_q == 4'd14);

endmodule

// File: rtl/lvds_tx.sv
// LVDS transmit serializer: pops I/Q words from the TX FIFO and sends them
// MSB-first, two bits per clock, back-to-back with a prefetch at pair 14.
// Optional build macro: LVDS_TX_SYNC_FORCE_EN (handled in lvds_tx_shifter).
module lvds_tx
  import lvds_pkg::*;
#(
  parameter logic [1:0] IDLE_PATTERN = 2'b00
) (
  input  logic             i_ddr_clk,
  input  logic             i_reset,
  input  logic             i_tx_enable,
  lvds_tx_if.master        fifo,
  output logic             o_fifo_read_clk,
  output logic [1:0]       o_ddr_data,
  output logic             o_underrun,
  output logic [1:0]       o_debug_state
);

  lvds_state_e state_q, state_d;
  logic        pending_q, pending_d;
  logic        underrun_q, underrun_d;
  logic        pull;
  logic        sh_load, sh_shift, sh_last, sh_prefetch;
  logic        can_pull;

  assign can_pull = i_tx_enable & ~fifo.fifo_empty;

  // Next-state, pull and shifter control; pull is blocked outright during reset.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    underrun_d = 1'b0;
    pull       = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pull = can_pull;
        if (can_pull) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sh_load = 1'b1;
        state_d = ST_TX;
      end
      ST_TX: begin
        sh_shift = 1'b1;
        if (sh_prefetch) begin
          pull = can_pull;
          if (can_pull) pending_d = 1'b1;
        end
        if (sh_last) begin
          if (pending_q) begin
            // Prefetched word is on fifo_data now: reload for a gapless join.
            sh_load   = 1'b1;
            pending_d = 1'b0;
          end else begin
            state_d    = ST_IDLE;
            underrun_d = i_tx_enable;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_reset) pull = 1'b0;
  end

  // FSM, pending flag and underrun pulse registers.
  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      underrun_q <= underrun_d;
    end
  end

  lvds_tx_shifter #(
    .IDLE_PATTERN (IDLE_PATTERN)
  ) u_shifter (
    .clk_i      (i_ddr_clk),
    .rst_i      (i_reset),
    .load_i     (sh_load),
    .shift_i    (sh_shift),
    .data_in_i  (fifo.fifo_data),
    .pair_out_o (o_ddr_data),
    .last_o     (sh_last),
    .prefetch_o (sh_prefetch)
  );

  assign fifo.fifo_pull  = pull;
  assign o_fifo_read_clk = i_ddr_clk;
  assign o_underrun      = underrun_q;
  assign o_debug_state   = state_q;

endmodule

// File: tb/tb_lvds_tx.sv
// Directed bench for lvds_tx with a queue-backed TX FIFO model.
module tb_lvds_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rd_clk;
  logic [1:0] ddr;
  logic       und;
  logic [1:0] dbg;

  lvds_tx_if f ();

  lvds_tx dut (
    .i_ddr_clk       (clk),
    .i_reset         (rst),
    .i_tx_enable     (en),
    .fifo            (f.master),
    .o_fifo_read_clk (rd_clk),
    .o_ddr_data      (ddr),
    .o_underrun      (und),
    .o_debug_state   (dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // FIFO model and scoreboard state
  logic [31:0] exp_q[$];
  logic        force_empty;
  int          n_chk  = 0;
  int          n_pass = 0;

  // snapshot of the cycle just completed (taken at the falling edge)
  logic       s_pull;
  logic [1:0] s_ddr;
  logic       s_und;
  logic [1:0] s_state;
  logic       s_rdclk_ok;

  task automatic upd_empty();
    f.fifo_empty = (exp_q.size() == 0) || force_empty;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: sample outputs mid-cycle, then service a pull on the edge.
  task automatic cyc();
    @(negedge clk);
    s_pull     = f.fifo_pull;
    s_ddr      = ddr;
    s_und      = und;
    s_state    = dbg;
    s_rdclk_ok = (rd_clk === clk);
    @(posedge clk);
    #1;
    if (s_pull && exp_q.size() > 0) f.fifo_data = exp_q.pop_front();
    upd_empty();
  endtask

  task automatic push(input logic [31:0] w);
    exp_q.push_back(w);
    upd_empty();
  endtask

  // IDLE cycle with pull, then LOAD cycle.
  task automatic start_word(input string tag);
    cyc();
    chk({tag, "_pull"}, 32'(s_pull), 32'd1);
    chk({tag, "_idle"}, 32'(s_state), 32'h0);
    cyc();
    chk({tag, "_load"}, 32'(s_state), 32'h1);
    chk({tag, "_load_pull"}, 32'(s_pull), 32'd0);
    chk({tag, "_load_ddr"}, 32'(s_ddr), 32'h0);
  endtask

  // npairs TX cycles of word w; optional enable drop / FIFO empty at a pair index.
  task automatic send_word(input string tag, input logic [31:0] w, input logic pull14,
                           input int npairs, input int drop_at, input int empty_at);
    for (int i = 0; i < npairs; i++) begin
      if (i == drop_at) en = 1'b0;
      if (i == empty_at) begin
        force_empty = 1'b1;
        upd_empty();
      end
      cyc();
      chk($sformatf("%s_pair%0d", tag, i), 32'(s_ddr), 32'(w[31-2*i -: 2]));
      chk($sformatf("%s_st%0d", tag, i), 32'(s_state), 32'h3);
      chk($sformatf("%s_pull%0d", tag, i), 32'(s_pull), (i == 14) ? 32'(pull14) : 32'd0);
      chk($sformatf("%s_und%0d", tag, i), 32'(s_und), 32'd0);
    end
  endtask

  // First cycle after a word: IDLE, idle pattern, underrun as expected.
  task automatic end_word(input string tag, input logic exp_und);
    cyc();
    chk({tag, "_end_und"}, 32'(s_und), 32'(exp_und));
    chk({tag, "_end_st"}, 32'(s_state), 32'h0);
    chk({tag, "_end_ddr"}, 32'(s_ddr), 32'h0);
  endtask

  logic [31:0] exp6;

  initial begin
    rst = 1'b1;
    en = 1'b0;
    force_empty = 1'b0;
    f.fifo_data = 32'h0;
    upd_empty();
`ifdef LVDS_TX_SYNC_FORCE_EN
    exp6 = 32'h8000_4000;
`else
    exp6 = 32'h0000_0000;
`endif

    // reset state, and no pull during reset even with data and enable
    cyc();
    cyc();
    chk("rst_state", 32'(s_state), 32'h0);
    chk("rst_ddr", 32'(s_ddr), 32'h0);
    chk("rst_und", 32'(s_und), 32'd0);
    chk("rst_rdclk", 32'(s_rdclk_ok), 32'd1);
    push(32'hA5A5_5A5A);
    en = 1'b1;
    cyc();
    chk("rst_pull", 32'(s_pull), 32'd0);
    rst = 1'b0;

    // 1: single word, then underrun
    start_word("t1");
    send_word("t1", 32'hA5A5_5A5A, 1'b0, 16, -1, -1);
    end_word("t1", 1'b1);
    cyc();
    chk("t1_und_once", 32'(s_und), 32'd0);
    chk("t1_idle_ddr", 32'(s_ddr), 32'h0);

    // 2: three queued words, gapless, prefetch at pair 14
    push(32'hBFFF_7FFF);
    push(32'h8000_4000);
    push(32'hA5A5_5A5A);
    start_word("t2");
    send_word("t2w1", 32'hBFFF_7FFF, 1'b1, 16, -1, -1);
    send_word("t2w2", 32'h8000_4000, 1'b1, 16, -1, -1);
    send_word("t2w3", 32'hA5A5_5A5A, 1'b0, 16, -1, -1);
    end_word("t2", 1'b1);
    chk("t2_fifo_drained", 32'(exp_q.size()), 32'd0);

    // 3: enable drops at pair 5 with a second word queued
    push(32'h8123_4567);
    push(32'hBFFF_7FFF);
    start_word("t3");
    send_word("t3w1", 32'h8123_4567, 1'b0, 16, 5, -1);
    end_word("t3", 1'b0);
    cyc();
    chk("t3_no_pull", 32'(s_pull), 32'd0);
    chk("t3_word_left", 32'(exp_q.size()), 32'd1);
    en = 1'b1;
    start_word("t3b");
    send_word("t3w2", 32'hBFFF_7FFF, 1'b0, 16, -1, -1);
    end_word("t3b", 1'b1);

    // 4: reset at pair 7, then a fresh pull
    push(32'hA5A5_5A5A);
    push(32'h8000_4000);
    start_word("t4");
    send_word("t4w1", 32'hA5A5_5A5A, 1'b0, 7, -1, -1);
    rst = 1'b1;
    cyc();
    chk("t4_c7_ddr", 32'(s_ddr), 32'h1);
    chk("t4_c7_pull", 32'(s_pull), 32'd0);
    cyc();
    chk("t4_rst_ddr", 32'(s_ddr), 32'h0);
    chk("t4_rst_state", 32'(s_state), 32'h0);
    chk("t4_rst_pull", 32'(s_pull), 32'd0);
    rst = 1'b0;
    start_word("t4b");
    send_word("t4w2", 32'h8000_4000, 1'b0, 16, -1, -1);
    end_word("t4b", 1'b1);

    // 5: FIFO goes empty exactly at pair 14
    push(32'hBFFF_7FFF);
    push(32'h8000_4000);
    start_word("t5");
    send_word("t5w1", 32'hBFFF_7FFF, 1'b0, 16, -1, 14);
    end_word("t5", 1'b1);
    force_empty = 1'b0;
    upd_empty();
    start_word("t5b");
    send_word("t5w2", 32'h8000_4000, 1'b0, 16, -1, -1);
    end_word("t5b", 1'b1);

    // 6: all-zero word (sync fields forced only in the forcing build)
    push(32'h0000_0000);
    start_word("t6");
    send_word("t6", exp6, 1'b0, 16, -1, -1);
    end_word("t6", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
